mem_dump_engine: RTL and testbench

//  Hardware counterpart of the bench-side memory dump. On START, sweeps an inclusive word-address

---
 rtl/mem_dump_engine_pkg.sv | 21 ++
 rtl/mem_dump_engine_fifo.sv | 62 ++++++
 rtl/mem_dump_engine.sv | 175 +++++++++++++++++
 tb/tb_mem_dump_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_engine_pkg.sv
// Shared definitions for the memory dump engine: default bus widths and FSM state encoding.
// Widths mirror the DA_VINCI project address/data index limits (+1).
package mem_dump_engine_pkg;

  localparam int ADDR_W_DEF = 26;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIN   = 3'd3,
    ST_ERRD  = 3'd4
  } state_e;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_dump_engine_fifo.sv
// First-word-fall-through synchronous FIFO holding {address, data} dump words.
// A push while full is accepted only when a pop happens in the same cycle.
module dump_fifo
  import mem_dump_engine_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF,
  parameter int DEPTH = 4,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  assign w_wr = i_push && (!o_full || i_pop);
  assign w_rd = i_pop && !o_empty;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_dump_engine.sv
// Sweeps an inclusive word-address range, reading one word per cycle under credit control,
// and streams {address, data} to a valid/ready consumer through a small FWFT buffer.
module mem_dump_engine
  import mem_dump_engine_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [ADDR_W-1:0] i_end_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data
);

  localparam int CNT_W = cnt_width(FIFO_DEPTH);
  localparam int OCC_W = CNT_W + 1;
  localparam int WORD_W = ADDR_W + DATA_W;

  state_e            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_end;

  logic [RD_LAT-1:0] r_pipe_vld;
  logic [ADDR_W-1:0] r_pipe_addr [RD_LAT];

  logic [OCC_W-1:0]  w_inflight;
  logic [OCC_W-1:0]  w_occ;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_drained;
  logic [WORD_W-1:0] w_fifo_din;
  logic [WORD_W-1:0] w_fifo_dout;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_dump_valid;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + OCC_W'(r_pipe_vld[i]);
    end
  end

  // Every outstanding read already owns a buffer slot, so returned data is never dropped.
  assign w_pop   = w_dump_valid && i_dump_ready;
  assign w_occ   = w_inflight + OCC_W'(w_fifo_count) - OCC_W'(w_pop);
  assign w_issue = (r_state == ST_ISSUE) && (w_occ < OCC_W'(FIFO_DEPTH));

  assign w_drained = (r_pipe_vld == '0) &&
                     ((w_fifo_count == '0) || ((w_fifo_count == CNT_W'(1)) && w_pop));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_start_addr <= i_end_addr) begin
              r_state <= ST_ISSUE;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_ERRD;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (w_issue && (r_addr == r_end)) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state <= ST_FIN;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        ST_ERRD: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Range registers are data: loaded on an accepted START, stepped only when a read issues.
  // The end compare happens before the increment so the top address never wraps to 0.
  always_ff @(posedge i_clk) begin
    if ((r_state == ST_IDLE) && i_start) begin
      r_addr <= i_start_addr;
      r_end  <= i_end_addr;
    end else if (w_issue && (r_addr != r_end)) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // Read-latency pipe: stage 0 is the cycle after the strobe, stage RD_LAT-1 meets MEM_RDATA.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_pipe_addr[0] <= r_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      r_pipe_addr[i] <= r_pipe_addr[i-1];
    end
  end

  assign w_push     = r_pipe_vld[RD_LAT-1];
  assign w_fifo_din = {r_pipe_addr[RD_LAT-1], i_mem_rdata};

  dump_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_fifo_din),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign w_dump_valid = !w_fifo_empty;

  // Outputs are forced to zero whenever their qualifier is low, so reset leaves every output at 0.
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_mem_read   = w_issue;
  assign o_mem_addr   = w_issue ? r_addr : '0;
  assign o_dump_valid = w_dump_valid;
  assign o_dump_addr  = w_dump_valid ? w_fifo_dout[WORD_W-1:DATA_W] : '0;
  assign o_dump_data  = w_dump_valid ? w_fifo_dout[DATA_W-1:0] : '0;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    w_push |-> (!w_fifo_full || w_pop));

endmodule

// File: tb/tb_mem_dump_engine.sv
// Scoreboard bench for mem_dump_engine: a latency-accurate memory model answers reads,
// expected read addresses and dump words are queued when each sweep is started.
module tb_mem_dump_engine;

  localparam int ADDR_W     = 26;
  localparam int DATA_W     = 32;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic [DATA_W-1:0] mem_rdata;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;

  mem_dump_engine #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_start_addr (start_addr),
    .i_end_addr   (end_addr),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_mem_addr   (mem_addr),
    .o_mem_read   (mem_read),
    .i_mem_rdata  (mem_rdata),
    .o_dump_valid (dump_valid),
    .i_dump_ready (dump_ready),
    .o_dump_addr  (dump_addr),
    .o_dump_data  (dump_data)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int c0 = 0;
  int rd0 = 0;
  int n_rd = 0;
  int n_acc = 0;
  bit saw_rd0 = 0;

  logic [ADDR_W-1:0]        rdq [$];
  logic [ADDR_W+DATA_W-1:0] sb  [$];
  logic [ADDR_W:0]          mq  [RD_LAT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] memf(input logic [ADDR_W-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction

  // Memory model: data for a read strobed in cycle k is presented in cycle k+RD_LAT.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) mq[i] <= '0;
    end else begin
      mq[0] <= {mem_read, mem_addr};
      for (int i = 1; i < RD_LAT; i++) mq[i] <= mq[i-1];
    end
  end

  always_comb begin
    mem_rdata = 32'hDEADBEEF;
    if (mq[RD_LAT-1][ADDR_W]) mem_rdata = memf(mq[RD_LAT-1][ADDR_W-1:0]);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Monitor: read addresses and accepted words against the queues, plus hold-while-stalled.
  initial begin
    bit                hold_pend;
    logic [ADDR_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_d;
    hold_pend = 0;
    hold_a = '0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 0;
      end else begin
        if (mem_read) begin
          n_rd++;
          if (mem_addr == '0) saw_rd0 = 1;
          if (rdq.size() == 0) chk("rd_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("rd_addr", 64'(mem_addr), 64'(rdq.pop_front()));
        end
        if (hold_pend)
          chk("dump_hold", 64'({dump_valid, dump_addr, dump_data}), 64'({1'b1, hold_a, hold_d}));
        if (dump_valid && dump_ready) begin
          n_acc++;
          if (sb.size() == 0) chk("dump_unexpected", 64'({dump_addr, dump_data}), 64'hFFFF_FFFF_FFFF_FFFF);
          else chk("dump_word", 64'({dump_addr, dump_data}), 64'(sb.pop_front()));
        end
        hold_pend = dump_valid && !dump_ready;
        hold_a = dump_addr;
        hold_d = dump_data;
      end
    end
  end

  task automatic start_sweep(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                             input int mode);
    @(posedge clk);
    #1;
    c0 = cyc;
    rd0 = n_rd;
    start = 1'b1;
    start_addr = sa;
    end_addr = ea;
    dump_ready = (mode == 0);
    if (sa <= ea) begin
      for (logic [ADDR_W:0] a = {1'b0, sa}; a <= {1'b0, ea}; a++) begin
        rdq.push_back(a[ADDR_W-1:0]);
        sb.push_back({a[ADDR_W-1:0], memf(a[ADDR_W-1:0])});
      end
    end
  endtask

  // mode 0: ready tied high; mode 1: ready low for 20 cycles, then toggling 1/0.
  task automatic wait_done(input int mode, input int n_words, input bit exp_err, input int restart_k);
    bit got;
    bit seen_busy;
    int exp_lat;
    got = 0;
    seen_busy = 0;
    exp_lat = exp_err ? 1 : n_words + RD_LAT + 2;
    for (int k = 1; k <= 600 && !got; k++) begin
      @(posedge clk);
      #1;
      if (k == restart_k) begin
        start = 1'b1;
        start_addr = 26'h2000000;
        end_addr = 26'h2000003;
      end else begin
        start = 1'b0;
      end
      dump_ready = (mode == 0) ? 1'b1 : ((k <= 20) ? 1'b0 : 1'((k % 2) == 1));
      @(negedge clk);
      if (busy) seen_busy = 1;
      if (mode == 1 && k == 20) chk("stall_reads", 64'(n_rd - rd0), 64'(FIFO_DEPTH));
      if (done) begin
        got = 1;
        chk("err_flag", 64'(err), 64'(exp_err));
        chk("busy_at_done", 64'(busy), 64'd0);
        if (mode == 0) chk("done_latency", 64'(cyc - c0), 64'(exp_lat));
      end
    end
    chk("done_seen", 64'(got), 64'd1);
    chk("busy_seen", 64'(seen_busy), 64'(!exp_err));
    chk("words_left", 64'(sb.size()), 64'd0);
    chk("reads_left", 64'(rdq.size()), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bit flag;
    rst = 1'b1;
    start = 1'b0;
    start_addr = '0;
    end_addr = '0;
    dump_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        64'({busy, done, err, mem_read, dump_valid, mem_addr, dump_addr}), 64'd0);
    chk("reset_data", 64'(dump_data), 64'd0);

    // Top-of-memory range: 22 words, must not wrap to address 0.
    saw_rd0 = 0;
    start_sweep(26'h3FFFFEA, 26'h3FFFFFF, 0);
    wait_done(0, 22, 0, -1);
    chk("no_read_of_0", 64'(saw_rd0), 64'd0);
    chk("top_read_count", 64'(n_rd - rd0), 64'd22);

    // Single-word range.
    start_sweep(26'h1000000, 26'h1000000, 0);
    wait_done(0, 1, 0, -1);
    chk("single_read_count", 64'(n_rd - rd0), 64'd1);

    // Reversed range: error completion, no reads.
    start_sweep(26'h1000005, 26'h1000000, 0);
    wait_done(0, 0, 1, -1);
    chk("err_no_reads", 64'(n_rd - rd0), 64'd0);

    // Back-pressure: credit stall, then toggling ready.
    start_sweep(26'h1000000, 26'h100000F, 1);
    wait_done(1, 16, 0, -1);

    // START mid-sweep with another range is ignored.
    start_sweep(26'h1000000, 26'h1000007, 0);
    wait_done(0, 8, 0, 3);

    // Reset mid-sweep after five delivered words.
    start_sweep(26'h1000000, 26'h100000F, 0);
    k = 0;
    rd0 = n_acc;
    while ((n_acc - rd0) < 5 && k < 100) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("abort_reached_5", 64'((n_acc - rd0) >= 5), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdq.delete();
    sb.delete();
    @(negedge clk);
    chk("abort_outputs",
        64'({busy, done, err, mem_read, dump_valid, mem_addr, dump_addr}), 64'd0);
    chk("abort_data", 64'(dump_data), 64'd0);
    flag = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy || mem_read || dump_valid) flag = 1;
    end
    chk("abort_quiet", 64'(flag), 64'd0);

    // Clean sweep after abort.
    start_sweep(26'h1000000, 26'h1000003, 0);
    wait_done(0, 4, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
